// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline control block.
//   state_e          : FSM state encoding (RUN / MEM_WAIT)
//   MEM_TIMEOUT_DEF  : default data-memory wait limit, in cycles
//   reg_hit()        : register-number match that never matches r0
package pipeline_ctrl_pkg;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_e;

    localparam int MEM_TIMEOUT_DEF = 16;

    // r0 is hard-wired to zero, so a write to it can never create a hazard.
    function automatic logic reg_hit(input logic [4:0] wr, input logic [4:0] rd);
        return (wr != 5'd0) && (wr == rd);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard detector (purely combinational).
// Ports:
//   ex_mem_read_i  : EX instruction is a load
//   ex_write_reg_i : EX destination register
//   id_rs_i/id_rt_i: ID source registers
//   id_uses_rt_i   : ID instruction actually reads rt
//   load_use_o     : ID needs the load result that is still in EX
module hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_write_reg_i,
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       id_uses_rt_i,
    output logic       load_use_o
);

    assign load_use_o = ex_mem_read_i &&
                        (reg_hit(ex_write_reg_i, id_rs_i) ||
                         (id_uses_rt_i && reg_hit(ex_write_reg_i, id_rt_i)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller for a 5-stage in-order pipeline.
// Handles load-use stalls, taken-branch flushes and data-memory wait states
// with a timeout that raises a sticky error.
// Ports:
//   clk, reset                    : clock, asynchronous active-high reset
//   id_rs, id_rt, id_uses_rt      : ID source operands
//   ex_mem_read, ex_write_reg     : EX load info
//   ex_branch_taken               : EX redirect
//   mem_access, dmem_ready        : MEM-stage memory handshake
//   pc_en .. mem_wb_en            : PC / pipeline register load enables
//   if_id_flush, id_ex_flush, mem_wb_flush : bubble insertion
//   dmem_req                      : data memory request
//   mem_err                       : sticky memory-timeout flag
//   stall_cycles                  : saturating count of cycles with pc_en=0
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_write_reg,
    input  logic             ex_branch_taken,
    input  logic             mem_access,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_flush,
    output logic             dmem_req,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles
);

    // Wait counter holds the number of MEM_WAIT cycles already spent stalled.
    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              err_q;
    logic [CNT_W-1:0]  stall_q;
    logic              err_set;
    logic              hold_c, req_c;
    logic              load_use;
    logic              pc_c, if_id_c, id_ex_c, ex_mem_c, mem_wb_c;
    logic              if_id_fl_c, id_ex_fl_c, mem_wb_fl_c;

    hazard_detect u_hazard (
        .ex_mem_read_i (ex_mem_read),
        .ex_write_reg_i(ex_write_reg),
        .id_rs_i       (id_rs),
        .id_rt_i       (id_rt),
        .id_uses_rt_i  (id_uses_rt),
        .load_use_o    (load_use)
    );

    // Next state: decide whether this cycle is held for memory or released.
    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        err_set = 1'b0;
        hold_c  = 1'b0;
        req_c   = 1'b0;
        case (state_q)
            ST_RUN: begin
                req_c = mem_access;
                if (mem_access && !dmem_ready) begin
                    hold_c  = 1'b1;
                    state_d = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_ready) begin
                    req_c   = 1'b1;
                    state_d = ST_RUN;
                end else if (wait_q == WAIT_LAST) begin
                    // Abort: release the pipeline without a request.
                    err_set = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    hold_c  = 1'b1;
                    req_c   = 1'b1;
                    wait_d  = wait_q + 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Output decode. Branch outranks load-use; both are ignored while held.
    always_comb begin
        pc_c        = 1'b0;
        if_id_c     = 1'b0;
        id_ex_c     = 1'b0;
        ex_mem_c    = 1'b0;
        mem_wb_c    = 1'b0;
        if_id_fl_c  = 1'b0;
        id_ex_fl_c  = 1'b0;
        mem_wb_fl_c = 1'b0;
        if (hold_c) begin
            mem_wb_c    = 1'b1;
            mem_wb_fl_c = 1'b1;
        end else begin
            pc_c     = 1'b1;
            if_id_c  = 1'b1;
            id_ex_c  = 1'b1;
            ex_mem_c = 1'b1;
            mem_wb_c = 1'b1;
            if (ex_branch_taken) begin
                if_id_fl_c = 1'b1;
                id_ex_fl_c = 1'b1;
            end else if (load_use) begin
                pc_c       = 1'b0;
                if_id_c    = 1'b0;
                id_ex_fl_c = 1'b1;
            end
        end
    end

    // Reset forces every control output low without waiting for a clock.
    assign pc_en        = pc_c        & ~reset;
    assign if_id_en     = if_id_c     & ~reset;
    assign id_ex_en     = id_ex_c     & ~reset;
    assign ex_mem_en    = ex_mem_c    & ~reset;
    assign mem_wb_en    = mem_wb_c    & ~reset;
    assign if_id_flush  = if_id_fl_c  & ~reset;
    assign id_ex_flush  = id_ex_fl_c  & ~reset;
    assign mem_wb_flush = mem_wb_fl_c & ~reset;
    assign dmem_req     = req_c       & ~reset;
    assign mem_err      = err_q;
    assign stall_cycles = stall_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            wait_q  <= '0;
            err_q   <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (err_set) err_q <= 1'b1;
            if (!pc_en && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

    localparam int TO = 4;
    localparam int CW = 4;
    localparam int SMAX = (1 << CW) - 1;

    // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_fl, id_ex_fl, mem_wb_fl, dmem_req}
    localparam logic [8:0] P_RUN = 9'b11111_000_0;
    localparam logic [8:0] P_LU  = 9'b00111_010_0;
    localparam logic [8:0] P_BR  = 9'b11111_110_0;
    localparam logic [8:0] P_MW  = 9'b00001_001_1;

    logic clk = 1'b0;
    logic reset;
    logic [4:0] id_rs, id_rt, ex_write_reg;
    logic id_uses_rt, ex_mem_read, ex_branch_taken, mem_access, dmem_ready;
    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_flush, id_ex_flush, mem_wb_flush, dmem_req, mem_err;
    logic [CW-1:0] stall_cycles;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model state
    bit m_wait;
    int m_waited;
    bit m_err;
    int m_stall;

    pipeline_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_write_reg(ex_write_reg),
        .ex_branch_taken(ex_branch_taken),
        .mem_access(mem_access), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .mem_wb_flush(mem_wb_flush), .dmem_req(dmem_req),
        .mem_err(mem_err), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    wire [8:0] outs = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                       if_id_flush, id_ex_flush, mem_wb_flush, dmem_req};

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       ur;
        logic       mr;
        logic [4:0] wr;
        logic       br;
        logic       ma;
        logic       rdy;
        logic [8:0] exp;
        int         stall;
        logic [8:0] exp_next;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                          input logic mr, input logic [4:0] wr, input logic br,
                          input logic ma, input logic rdy);
        id_rs = rs; id_rt = rt; id_uses_rt = ur; ex_mem_read = mr;
        ex_write_reg = wr; ex_branch_taken = br; mem_access = ma; dmem_ready = rdy;
    endtask

    task automatic idle;
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at posedge+1 of the first cycle out of reset.
    task automatic do_reset;
        reset = 1'b1;
        idle();
        #1;
        chk("reset_outs", 32'(outs), 32'd0);
        chk("reset_err", 32'(mem_err), 32'd0);
        chk("reset_stall", 32'(stall_cycles), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_wait = 0; m_waited = 0; m_err = 0; m_stall = 0;
    endtask

    // Expected outputs from the current inputs and the model's notion of
    // whether an access is outstanding and for how long it has waited.
    function automatic logic [8:0] model_out(output bit done, output bit tmo);
        bit lu;
        logic [8:0] o;
        lu = ex_mem_read && (ex_write_reg != 0) &&
             ((ex_write_reg == id_rs) || (id_uses_rt && ex_write_reg == id_rt));
        tmo  = m_wait && !dmem_ready && (m_waited + 1 >= TO);
        done = m_wait ? (dmem_ready || tmo) : (!mem_access || dmem_ready);
        if (!done) return P_MW;
        o = ex_branch_taken ? P_BR : (lu ? P_LU : P_RUN);
        o[0] = m_wait ? !tmo : mem_access;
        return o;
    endfunction

    initial begin
        bit done, tmo;
        logic [8:0] e;

        reset = 1'b1;
        idle();

        // rs rt ur mr wr br ma rdy | outputs | stall after | outputs next cycle (idle)
        tbl[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, P_RUN,        0, P_RUN};
        tbl[1]  = '{5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, P_LU,         1, P_RUN};
        tbl[2]  = '{5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, P_RUN,        0, P_RUN};
        tbl[3]  = '{5'd2, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, P_RUN,        0, P_RUN};
        tbl[4]  = '{5'd2, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, P_LU,         1, P_RUN};
        tbl[5]  = '{5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, P_BR,         0, P_RUN};
        tbl[6]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, P_BR,         0, P_RUN};
        tbl[7]  = '{5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, P_RUN,        0, P_RUN};
        tbl[8]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, P_RUN | 9'd1, 0, P_RUN};
        tbl[9]  = '{5'd7, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b1, 1'b1, P_LU | 9'd1,  1, P_RUN};
        tbl[10] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, P_MW,         1, P_MW};
        tbl[11] = '{5'd3, 5'd0, 1'b0, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0, P_MW,         1, P_MW};

        for (int i = 0; i < 12; i++) begin
            do_reset();
            set_in(tbl[i].rs, tbl[i].rt, tbl[i].ur, tbl[i].mr, tbl[i].wr,
                   tbl[i].br, tbl[i].ma, tbl[i].rdy);
            @(negedge clk);
            chk($sformatf("vec%0d_outs", i), 32'(outs), 32'(tbl[i].exp));
            nxt();
            idle();
            chk($sformatf("vec%0d_stall", i), 32'(stall_cycles), 32'(tbl[i].stall));
            @(negedge clk);
            chk($sformatf("vec%0d_next", i), 32'(outs), 32'(tbl[i].exp_next));
        end

        // Memory wait: not ready for the request cycle plus 3 waits, ready on the 4th wait.
        do_reset();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("wait_hold%0d", c), 32'(outs), 32'(P_MW));
            nxt();
        end
        // LU and branch presented during the release; branch wins.
        set_in(5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        chk("wait_release", 32'(outs), 32'(P_BR | 9'd1));
        chk("wait_stall", 32'(stall_cycles), 32'd4);
        nxt();
        idle();
        @(negedge clk);
        chk("wait_after", 32'(outs), 32'(P_RUN));

        // Timeout: ready never arrives.
        do_reset();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("tmo_hold%0d", c), 32'(outs), 32'(P_MW));
            nxt();
        end
        @(negedge clk);
        chk("tmo_release", 32'(outs), 32'(P_RUN));
        chk("tmo_err_pre", 32'(mem_err), 32'd0);
        nxt();
        idle();
        @(negedge clk);
        chk("tmo_err_set", 32'(mem_err), 32'd1);
        chk("tmo_req_low", 32'(dmem_req), 32'd0);
        nxt();
        nxt();
        @(negedge clk);
        chk("tmo_err_held", 32'(mem_err), 32'd1);

        // Asynchronous reset in MEM_WAIT (mem_err already set from above).
        nxt();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        nxt();
        @(negedge clk);
        chk("rstw_inwait", 32'(outs), 32'(P_MW));
        #2;
        reset = 1'b1;
        #1;
        chk("rstw_outs", 32'(outs), 32'd0);
        chk("rstw_err", 32'(mem_err), 32'd0);
        chk("rstw_stall", 32'(stall_cycles), 32'd0);
        nxt();
        reset = 1'b0;
        idle();
        m_wait = 0; m_waited = 0; m_err = 0; m_stall = 0;
        @(negedge clk);
        chk("rstw_first", 32'(outs), 32'(P_RUN));

        // Randomized run against the reference model.
        do_reset();
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 7) == 0),
                   1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 9) < 4));
            @(negedge clk);
            e = model_out(done, tmo);
            chk("rnd_outs", 32'(outs), 32'(e));
            chk("rnd_err", 32'(mem_err), 32'(m_err));
            chk("rnd_stall", 32'(stall_cycles), 32'(m_stall));
            if (!e[8]) m_stall = (m_stall >= SMAX) ? SMAX : m_stall + 1;
            if (tmo) m_err = 1;
            if (done) begin
                m_wait = 0;
                m_waited = 0;
            end else if (m_wait) begin
                m_waited++;
            end else begin
                m_wait = 1;
            end
            nxt();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
